// File: rtl/key_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module   : key_bcd_counter
// Brief    : Debounced push-button up/down/clear NUM_DIGITS BCD counter with
//            registered active-low seven-segment outputs.
// Revision : 1.0 - initial release
// ============================================================================
module key_bcd_counter #(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLANK_LEADING   = 1
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [2:0]              KEY,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic [4*NUM_DIGITS-1:0] COUNT_BCD,
    output logic                    WRAP
);

    localparam int              c_CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_DB_LAST = c_CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [6:0]      c_BLANK   = 7'b1111111;
    localparam logic [6:0]      c_ZERO    = 7'b0000001;

    logic [2:0]              r_sync1;
    logic [2:0]              r_sync2;
    logic [2:0]              r_db_state;
    logic [2:0]              r_db_prev;
    logic [2:0]              r_press;
    logic [c_CW-1:0]         r_db_cnt [3];
    logic [4*NUM_DIGITS-1:0] r_count;
    logic                    r_wrap;
    logic [7*NUM_DIGITS-1:0] r_hex;

    logic [4*NUM_DIGITS-1:0] w_inc;
    logic [4*NUM_DIGITS-1:0] w_dec;
    logic                    w_carry;
    logic                    w_borrow;
    logic [7*NUM_DIGITS-1:0] w_hex;
    logic                    w_zero_above;

    function automatic logic [6:0] seg_encode(input logic [3:0] i_digit);
        case (i_digit)
            4'd0:    seg_encode = 7'b0000001;
            4'd1:    seg_encode = 7'b1001111;
            4'd2:    seg_encode = 7'b0010010;
            4'd3:    seg_encode = 7'b0000110;
            4'd4:    seg_encode = 7'b1001100;
            4'd5:    seg_encode = 7'b0100100;
            4'd6:    seg_encode = 7'b0100000;
            4'd7:    seg_encode = 7'b0001111;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0000100;
            default: seg_encode = c_BLANK;
        endcase
    endfunction

    // A counter only runs while the synchronised key disagrees with the
    // accepted state, so any glitch shorter than the window resets it.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1    <= '1;
            r_sync2    <= '1;
            r_db_state <= '1;
            r_db_prev  <= '1;
            r_press    <= '0;
            for (int k = 0; k < 3; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            r_sync1   <= KEY;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_state;
            r_press   <= r_db_prev & ~r_db_state;
            for (int k = 0; k < 3; k++) begin
                if (r_sync2[k] != r_db_state[k]) begin
                    if (r_db_cnt[k] == c_DB_LAST) begin
                        r_db_state[k] <= r_sync2[k];
                        r_db_cnt[k]   <= '0;
                    end else begin
                        r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                    end
                end else begin
                    r_db_cnt[k] <= '0;
                end
            end
        end
    end

    always_comb begin
        w_inc    = r_count;
        w_dec    = r_count;
        w_carry  = 1'b1;
        w_borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    w_borrow        = 1'b0;
                end
            end
        end
    end

    // A carry/borrow surviving past the top digit is exactly the wrap case.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (r_press[2]) begin
                r_count <= '0;
            end else if (r_press[0] && !r_press[1]) begin
                r_count <= w_inc;
                r_wrap  <= w_carry;
            end else if (r_press[1] && !r_press[0]) begin
                r_count <= w_dec;
                r_wrap  <= w_borrow;
            end
        end
    end

    always_comb begin
        w_hex        = '0;
        w_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above && (r_count[4*i +: 4] == 4'd0);
            if ((BLANK_LEADING != 0) && (i > 0) && w_zero_above) begin
                w_hex[7*i +: 7] = c_BLANK;
            end else begin
                w_hex[7*i +: 7] = seg_encode(r_count[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_hex[7*i +: 7] <= ((BLANK_LEADING != 0) && (i > 0)) ? c_BLANK : c_ZERO;
            end
        end else begin
            r_hex <= w_hex;
        end
    end

    assign HEX       = r_hex;
    assign COUNT_BCD = r_count;
    assign WRAP      = r_wrap;

endmodule
`default_nettype wire
